seg_scan_display: RTL
=====================

Name: seg_scan_display

Overview:
- Parametrised multiplexed seven-segment display driver.
- Takes a binary value on a load strobe and converts it to BCD over several cycles (sequential double-dabble).
- Drives NUM_DIGITS common-cathode/anode digits with a built-in refresh prescaler, optional leading-zero blanking and an overflow indication.
- Sits between the CPU output register and the board pins, replacing the fixed 3-digit, 8-bit, derived-clock scan arrangement.

Parameters:
- DATA_W, 8, width of the binary input value (1..20).
- NUM_DIGITS, 3, number of multiplexed digits (1..8).
- REFRESH_DIV, 32768, clk cycles each digit stays selected (>=2).
- SEG_ACTIVE_LOW, 0, 1 = segment outputs inverted (lit = 0).
- DIG_ACTIVE_LOW, 1, 1 = digit select lit = 0.
- BLANK_LEADING, 1, 1 = blank zero digits above the most significant non-zero digit.

Ports:
- clk, in, 1, single system clock; all logic on its rising edge.
- reset, in, 1, synchronous, active-low reset (sampled on rising clk; 0 = reset).
- value, in, DATA_W, binary number to display; sampled only when load is accepted.
- load, in, 1, request conversion/display of value.
- busy, out, 1, conversion in progress.
- seg, out, 7, segments {a,b,c,d,e,f,g}, seg[6] = a; polarity per SEG_ACTIVE_LOW.
- dig, out, NUM_DIGITS, digit selects, dig[0] = ones digit; exactly one active, or none.

Behaviour:
Reset (reset == 0 at a rising edge):
- Converter state IDLE, busy = 0, pending flag cleared.
- Display BCD = 0, digit index = 0, prescaler = 0.
- Registered outputs: dig selects digit 0 only; seg = glyph "0".
- Reset mid-conversion aborts the conversion; the display stays at 0.

Converter FSM (IDLE, SHIFT, DONE):
- IDLE
  - On load: capture value into the shift register.
  - Clear the BCD work register (4*NUM_DIGITS bits) and the shift counter.
  - Go to SHIFT; busy = 1 from the next cycle.
- SHIFT
  - Each cycle: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1.
  - After DATA_W shifts, go to DONE.
- DONE (one cycle)
  - Commit the work register and the overflow flag (captured value > 10^NUM_DIGITS - 1) to the display registers.
  - If pending is set: restart with the pending value (return to SHIFT, busy stays 1).
  - Otherwise: return to IDLE, busy = 0.
- Latency:
  - load sampled at edge t.
  - New digits are visible in the display registers after edge t + DATA_W + 1.
  - Outputs show them when the scan reaches each digit.
- load while busy
  - Latch value into the pending register and set pending.
  - A later load overwrites the pending value (last wins). Nothing is lost except superseded values.
- load in the same cycle as DONE: treated as pending and restarted immediately.
- The display shows the old value during the whole conversion; no partial digits ever appear.

Scan:
- Prescaler counts 0..REFRESH_DIV-1.
- On wrap, the digit index increments; NUM_DIGITS-1 wraps to 0.
- seg and dig are registered and change on the same edge, so there is no ghosting mismatch.

Glyphs:
- Digits 0-9 use standard patterns.
- Nibbles above 9 cannot occur; map them to blank.

Blanking:
- With BLANK_LEADING = 1, a digit is blank when it and all higher digits are 0.
- The ones digit is never blanked.

Overflow:
- All digits show "-" (segment g only) until the next in-range value is committed.

Arithmetic and clocking:
- All arithmetic is unsigned.
- No derived clocks.

Decomposition:
- Package seg_pkg holds:
  - The conversion FSM state enum.
  - The 7-bit glyph constants: GLYPH_0..GLYPH_9, GLYPH_DASH, GLYPH_BLANK.
  - A function digit_to_glyph(nibble).
- One sub-module: bin_to_bcd_seq, the iterative DATA_W -> 4*NUM_DIGITS converter with start/busy/done. It owns the FSM and the overflow compare.
- The top level owns pending/load handling, display registers, prescaler, scan and polarity.

Test Plan:
Unless noted, benches use DATA_W = 8, NUM_DIGITS = 3, REFRESH_DIV = 4, SEG_ACTIVE_LOW = 0, DIG_ACTIVE_LOW = 1.
- Reset:
  - Stimulus: hold reset = 0 for 3 cycles, release.
  - Required: busy = 0; dig = 3'b110; seg = glyph 0 (7'b1111110).
  - Required: scan advances every 4 cycles through 110 -> 101 -> 011 -> 110.
- Conversion timing:
  - Stimulus: load value = 255.
  - Required: busy high for DATA_W + 1 = 9 cycles.
  - Required: after commit, the scan shows 5, 5, 2 on digits 0, 1, 2.
  - Required: the old value is displayed until commit.
- Blanking and BLANK_LEADING = 0:
  - Stimulus: load 7 with BLANK_LEADING = 1.
  - Required: digits 2 and 1 show seg = 0000000; digit 0 shows 7 (1110000).
  - Stimulus: same load with BLANK_LEADING = 0.
  - Required: display shows 0, 0, 7.
- Back-to-back loads:
  - Stimulus: load 12, then load 34 and load 56 during busy.
  - Required: commits 12, then 56; 34 is never displayed; busy stays continuous across the restart.
- Overflow:
  - Stimulus: DATA_W = 10, load 1000.
  - Required: all digits show dash (0000001).
  - Stimulus: load 999.
  - Required: shows 9, 9, 9.
- Reset mid-conversion:
  - Stimulus: assert reset 3 cycles after load of 200.
  - Required: busy = 0 next cycle; display shows 0; 200 is never shown.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared types, glyph table and helpers
// for the scanned seven-segment display.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  // Segment order {a,b,c,d,e,f,g}, lit = 1
  localparam logic [6:0] GLYPH_0     = 7'b1111110;
  localparam logic [6:0] GLYPH_1     = 7'b0110000;
  localparam logic [6:0] GLYPH_2     = 7'b1101101;
  localparam logic [6:0] GLYPH_3     = 7'b1111001;
  localparam logic [6:0] GLYPH_4     = 7'b0110011;
  localparam logic [6:0] GLYPH_5     = 7'b1011011;
  localparam logic [6:0] GLYPH_6     = 7'b1011111;
  localparam logic [6:0] GLYPH_7     = 7'b1110000;
  localparam logic [6:0] GLYPH_8     = 7'b1111111;
  localparam logic [6:0] GLYPH_9     = 7'b1111011;
  localparam logic [6:0] GLYPH_DASH  = 7'b0000001;
  localparam logic [6:0] GLYPH_BLANK = 7'b0000000;

  function automatic logic [6:0] digit_to_glyph(
    input logic [3:0] nibble
  );
    logic [6:0] g;
    unique case (nibble)
      4'd0:    g = GLYPH_0;
      4'd1:    g = GLYPH_1;
      4'd2:    g = GLYPH_2;
      4'd3:    g = GLYPH_3;
      4'd4:    g = GLYPH_4;
      4'd5:    g = GLYPH_5;
      4'd6:    g = GLYPH_6;
      4'd7:    g = GLYPH_7;
      4'd8:    g = GLYPH_8;
      4'd9:    g = GLYPH_9;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

  function automatic int unsigned pow10(
    input int n
  );
    int unsigned p;
    p = 1;
    for (int i = 0; i < n; i++) begin
      p = p * 10;
    end
    return p;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq.sv
// Iterative double-dabble converter:
// one shift per cycle, DATA_W shifts.
module bin_to_bcd_seq
  import seg_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int NUM_DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       din,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    ovf
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned MAX_V =
    pow10(NUM_DIGITS) - 1;
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DATA_W - 1);

  conv_state_t       state_q;
  conv_state_t       state_d;
  logic [DATA_W-1:0] bin_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [BCD_W-1:0]  bcd_adj;
  logic [CNT_W-1:0]  cnt_q;
  logic              ovf_q;
  logic              accept;

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign bcd    = bcd_q;
  assign ovf    = ovf_q;
  assign accept = start && (state_q != ST_SHIFT);

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: DONE lasts one cycle, may restart
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == LAST) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = start ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Add-3 correction on every nibble >= 5
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end else begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4];
      end
    end
  end

  // Datapath: capture on accept, shift in SHIFT
  always_ff @(posedge clk) begin
    if (!reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      bin_q <= din;
      bcd_q <= '0;
      cnt_q <= '0;
      ovf_q <= (32'(din) > MAX_V);
    end else if (state_q == ST_SHIFT) begin
      bcd_q <= BCD_W'({bcd_adj, bin_q[DATA_W-1]});
      bin_q <= bin_q << 1;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed seven-segment driver with
// sequential BCD conversion and scan.
module seg_scan_display
  import seg_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int NUM_DIGITS     = 3,
  parameter int REFRESH_DIV    = 32768,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  load,
  output logic                  busy,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] dig
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0] SEG_INV =
    {7{SEG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] DIG_INV =
    {NUM_DIGITS{DIG_ACTIVE_LOW != 0}};
  localparam logic [NUM_DIGITS-1:0] DIG0 =
    NUM_DIGITS'(1);

  logic                  conv_busy;
  logic                  conv_done;
  logic                  conv_start;
  logic [DATA_W-1:0]     conv_din;
  logic [BCD_W-1:0]      conv_bcd;
  logic                  conv_ovf;
  logic                  pend_q;
  logic [DATA_W-1:0]     pend_val_q;
  logic [BCD_W-1:0]      disp_bcd_q;
  logic                  disp_ovf_q;
  logic [PRE_W-1:0]      pre_q;
  logic [IDX_W-1:0]      idx_q;
  logic [NUM_DIGITS-1:0] blank_d;
  logic                  zero_hi;
  logic [6:0]            glyph_d;
  logic [NUM_DIGITS-1:0] dsel_d;
  logic [6:0]            seg_q;
  logic [NUM_DIGITS-1:0] dig_q;

  // A fresh load beats an older pending value
  assign conv_start = load | pend_q;
  assign conv_din   = load ? value : pend_val_q;
  assign busy       = conv_busy;
  assign seg        = seg_q;
  assign dig        = dig_q;

  bin_to_bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .din   (conv_din),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd),
    .ovf   (conv_ovf)
  );

  // Pending slot: last load during busy wins
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q     <= 1'b0;
      pend_val_q <= '0;
    end else if (conv_done) begin
      pend_q     <= 1'b0;
    end else if (load && conv_busy) begin
      pend_q     <= 1'b1;
      pend_val_q <= value;
    end
  end

  // Display registers change only on commit
  always_ff @(posedge clk) begin
    if (!reset) begin
      disp_bcd_q <= '0;
      disp_ovf_q <= 1'b0;
    end else if (conv_done) begin
      disp_bcd_q <= conv_bcd;
      disp_ovf_q <= conv_ovf;
    end
  end

  // Refresh prescaler and digit index
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q <= '0;
      idx_q <= '0;
    end else if (pre_q == PRE_LAST) begin
      pre_q <= '0;
      if (idx_q == IDX_LAST) begin
        idx_q <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end else begin
      pre_q <= pre_q + PRE_W'(1);
    end
  end

  // Leading-zero mask, scanned from the top
  always_comb begin
    zero_hi = 1'b1;
    blank_d = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_hi = zero_hi &
        (disp_bcd_q[4*i +: 4] == 4'd0);
      blank_d[i] = (BLANK_LEADING != 0) &&
        (i != 0) && zero_hi;
    end
  end

  // Glyph and select for the current digit
  always_comb begin
    glyph_d = GLYPH_BLANK;
    dsel_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        dsel_d[i] = 1'b1;
        glyph_d = blank_d[i] ? GLYPH_BLANK :
          digit_to_glyph(disp_bcd_q[4*i +: 4]);
      end
    end
    if (disp_ovf_q) glyph_d = GLYPH_DASH;
  end

  // seg and dig registered together
  always_ff @(posedge clk) begin
    if (!reset) begin
      seg_q <= GLYPH_0 ^ SEG_INV;
      dig_q <= DIG0 ^ DIG_INV;
    end else begin
      seg_q <= glyph_d ^ SEG_INV;
      dig_q <= dsel_d ^ DIG_INV;
    end
  end

endmodule
